// File: rtl/router_merge_buffer.sv
// router_merge_buffer: credit-flow-controlled output FIFO after the quadtree merge stage.
// Optional tail-address coalescing is enabled by defining ROUTER_MERGE_COALESCE_EN.
module router_merge_buffer #(
  parameter int FLIT_WIDTH  = 36,
  parameter int DEPTH       = 4,
  parameter int CREDIT_INIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    merge_en,
  input  logic [FLIT_WIDTH-1:0]   merge_data,
  output logic                    merge_stall,
  output logic                    out_valid,
  output logic [FLIT_WIDTH-1:0]   out_data,
  input  logic                    credit_in,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int AW = $clog2(DEPTH);
  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0] credits;
  logic full, empty, send, hit, accept, push;
  assign full  = fifo_count == (AW+1)'(DEPTH);
  assign empty = fifo_count == '0;
  assign send  = !empty && credits != '0;
`ifdef ROUTER_MERGE_COALESCE_EN
  logic [AW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - 1'b1;
  // a lone tail that is leaving this cycle cannot absorb the flit
  assign hit = !empty && mem[tail_ptr][31:16] == merge_data[31:16] &&
               (fifo_count != (AW+1)'(1) || !send);
`else
  assign hit = 1'b0;
`endif
  assign merge_stall = full && !hit;
  assign accept      = merge_en && !merge_stall;
  assign push        = accept && !hit;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= merge_data;
`ifdef ROUTER_MERGE_COALESCE_EN
    else if (accept) mem[tail_ptr][15:0] <= mem[tail_ptr][15:0] + merge_data[15:0];
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      credits    <= 4'(CREDIT_INIT);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (send) rd_ptr <= rd_ptr + 1'b1;
      if (send) out_data <= mem[rd_ptr];
      out_valid  <= send;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(send);
      credits    <= (credit_in && !send && credits != 4'(CREDIT_INIT)) ? credits + 1'b1 :
                    (send && !credit_in) ? credits - 1'b1 : credits;
    end
  end
endmodule
